// File: rtl/mod_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mod_counter_pkg
//  Description : Shared types and constants for the mod_counter block.
//                Holds the RUN/DONE state type plus the mode and direction
//                encodings used on the mode and up_dn inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
package mod_counter_pkg;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      DONE = 1'b1
   } state_e;

   localparam logic MODE_WRAP    = 1'b0;
   localparam logic MODE_ONESHOT = 1'b1;

   localparam logic DIR_DOWN = 1'b0;
   localparam logic DIR_UP   = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mod_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mod_counter_if
//  Description : Control/status bundle of the modulo counter.
//                master : drives en, up_dn, mode, prescale, max_val, load,
//                         load_val; observes out, tc, done.
//                slave  : the counter itself (mirror directions).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mod_counter_if #(
   parameter int WIDTH = 8,
   parameter int PRE_W = 8
);
   logic             en;
   logic             up_dn;
   logic             mode;
   logic [PRE_W-1:0] prescale;
   logic [WIDTH-1:0] max_val;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] out;
   logic             tc;
   logic             done;

   modport master (
      output en, up_dn, mode, prescale, max_val, load, load_val,
      input  out, tc, done
   );

   modport slave (
      input  en, up_dn, mode, prescale, max_val, load, load_val,
      output out, tc, done
   );
endinterface
`default_nettype wire

// File: rtl/mod_counter_tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Enable-gated prescaler. Emits one tick every prescale+1
//                enabled cycles (every enabled cycle when prescale = 0).
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                en            - count enable; en=0 freezes the phase
//                clr           - synchronous clear of the phase counter
//                prescale      - divisor minus one
//                tick          - combinational, derived from registered pcnt
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
   parameter int PRE_W = 8
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             en,
   input  wire logic             clr,
   input  wire logic [PRE_W-1:0] prescale,
   output logic                  tick
);

   logic [PRE_W-1:0] pcnt_q;
   logic [PRE_W-1:0] pcnt_d;

   // >= rather than == so that lowering prescale below the current phase
   // fires on the very next enabled cycle instead of running to wrap-around.
   assign tick = en && (pcnt_q >= prescale);

   always_comb begin
      pcnt_d = pcnt_q;
      if (clr) begin
         pcnt_d = '0;
      end else if (tick) begin
         pcnt_d = '0;
      end else if (en) begin
         pcnt_d = pcnt_q + PRE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mod_counter
//  Description : Parametrised up/down modulo counter with prescaler,
//                parallel load, wrap or one-shot mode and a registered
//                terminal-count pulse.
//  Ports       : clk, rst - clock, synchronous active-high reset
//                bus      - mod_counter_if.slave:
//                           en, up_dn, mode, prescale, max_val, load,
//                           load_val in; out, tc, done out (all registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module mod_counter
   import mod_counter_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int PRE_W = 8
) (
   input  wire logic     clk,
   input  wire logic     rst,
   mod_counter_if.slave  bus
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             tc_q, tc_d;
   logic             done_q, done_d;
   logic             tick;
   logic             terminal;

   tick_prescaler #(
      .PRE_W (PRE_W)
   ) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.en),
      .clr      (bus.load),
      .prescale (bus.prescale),
      .tick     (tick)
   );

   // Terminal test follows the direction sampled on this edge. Counting up
   // uses >= so a value loaded above max_val wraps on its first tick.
   assign terminal = (bus.up_dn == DIR_UP) ? (out_q >= bus.max_val)
                                           : (out_q == '0);

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      tc_d    = 1'b0;
      done_d  = done_q;

      if (bus.load) begin
         out_d   = bus.load_val;
         done_d  = 1'b0;
         state_d = RUN;
      end else begin
         case (state_q)
            RUN: begin
               if (tick) begin
                  if (terminal) begin
                     tc_d = 1'b1;
                     if (bus.mode == MODE_ONESHOT) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                     end else if (bus.up_dn == DIR_UP) begin
                        out_d = '0;
                     end else begin
                        out_d = bus.max_val;
                     end
                  end else if (bus.up_dn == DIR_UP) begin
                     out_d = out_q + WIDTH'(1);
                  end else begin
                     out_d = out_q - WIDTH'(1);
                  end
               end
            end
            // Halted: only load or rst leave this state, even if mode
            // returns to wrap.
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         out_q   <= '0;
         tc_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         tc_q    <= tc_d;
         done_q  <= done_d;
      end
   end

   assign bus.out  = out_q;
   assign bus.tc   = tc_q;
   assign bus.done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mod_counter
//  Description : Self-checking bench for mod_counter with a behavioural
//                reference model and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_counter;

   localparam int WIDTH = 8;
   localparam int PRE_W = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mod_counter_if #(.WIDTH(WIDTH), .PRE_W(PRE_W)) bus ();

   mod_counter #(
      .WIDTH (WIDTH),
      .PRE_W (PRE_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state: counter value, prescaler phase, outputs, halt.
   logic [WIDTH-1:0] m_out;
   int               m_pcnt;
   logic             m_tc;
   logic             m_done;
   bit               m_halted;

   function automatic void model_step();
      bit tick;
      bit at_end;
      if (rst) begin
         m_out = '0; m_tc = 1'b0; m_done = 1'b0; m_pcnt = 0; m_halted = 0;
      end else if (bus.load) begin
         m_out = bus.load_val; m_tc = 1'b0; m_done = 1'b0; m_pcnt = 0; m_halted = 0;
      end else begin
         tick = bus.en && (m_pcnt >= int'(bus.prescale));
         if (bus.en) m_pcnt = tick ? 0 : m_pcnt + 1;
         m_tc = 1'b0;
         if (tick && !m_halted) begin
            at_end = bus.up_dn ? (int'(m_out) >= int'(bus.max_val)) : (m_out == 0);
            if (at_end) begin
               m_tc = 1'b1;
               if (bus.mode) begin
                  m_halted = 1; m_done = 1'b1;
               end else begin
                  m_out = bus.up_dn ? '0 : bus.max_val;
               end
            end else begin
               m_out = bus.up_dn ? WIDTH'((int'(m_out) + 1) % 256)
                                 : WIDTH'(int'(m_out) - 1);
            end
         end
      end
   endfunction

   // Advance model and DUT by one edge, then settle for sampling.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_inputs(input logic en, input logic up, input logic md,
                             input int pre, input int mx);
      bus.en = en; bus.up_dn = up; bus.mode = md;
      bus.prescale = PRE_W'(pre); bus.max_val = WIDTH'(mx);
   endtask

   task automatic do_load(input int v);
      bus.load = 1'b1; bus.load_val = WIDTH'(v);
      cycle();
      bus.load = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_inputs(1'b1, 1'b1, 1'b0, 0, 5);
      bus.load = 1'b0; bus.load_val = '0;
      cycle();
      checks++;
      if (bus.out !== 8'd0 || bus.tc !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset: out=%0d tc=%b done=%b required out=0 tc=0 done=0",
                  bus.out, bus.tc, bus.done);
      end
      rst = 1'b0;
   endtask

   task automatic test_wrap();
      int exp_out [7] = '{1, 2, 3, 4, 5, 0, 1};
      bit exp_tc  [7] = '{0, 0, 0, 0, 0, 1, 0};
      for (int i = 0; i < 7; i++) begin
         cycle();
         checks++;
         if (bus.out !== WIDTH'(exp_out[i]) || bus.tc !== exp_tc[i] || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL wrap step %0d: out=%0d tc=%b done=%b required out=%0d tc=%b done=0",
                     i, bus.out, bus.tc, bus.done, exp_out[i], exp_tc[i]);
         end
      end
   endtask

   task automatic test_prescale_down();
      set_inputs(1'b1, 1'b0, 1'b0, 2, 3);
      do_load(3);
      for (int i = 0; i < 4; i++) cycle();
      checks++;
      if (bus.out !== 8'd2) begin
         errors++;
         $display("FAIL presc_before_freeze: out=%0d required 2", bus.out);
      end
      bus.en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         checks++;
         if (bus.out !== 8'd2 || bus.tc !== 1'b0) begin
            errors++;
            $display("FAIL presc_freeze %0d: out=%0d tc=%b required out=2 tc=0", i, bus.out, bus.tc);
         end
      end
      bus.en = 1'b1;
      cycle();
      cycle();
      checks++;
      if (bus.out !== 8'd1) begin
         errors++;
         $display("FAIL presc_phase_kept: out=%0d required 1", bus.out);
      end
      for (int i = 0; i < 6; i++) begin
         cycle();
         checks++;
         if (bus.out !== m_out || bus.tc !== m_tc || bus.done !== m_done) begin
            errors++;
            $display("FAIL presc_model %0d: out=%0d tc=%b done=%b required out=%0d tc=%b done=%b",
                     i, bus.out, bus.tc, bus.done, m_out, m_tc, m_done);
         end
      end
      checks++;
      if (bus.out !== 8'd3) begin
         errors++;
         $display("FAIL presc_reload_max: out=%0d required 3", bus.out);
      end
   endtask

   task automatic test_oneshot();
      int tc_count = 0;
      set_inputs(1'b1, 1'b1, 1'b1, 0, 4);
      do_load(0);
      for (int i = 0; i < 15; i++) begin
         if (i == 8) bus.mode = 1'b0;   // leaving one-shot must not restart
         cycle();
         if (bus.tc === 1'b1) tc_count++;
         checks++;
         if (bus.out !== m_out || bus.tc !== m_tc || bus.done !== m_done) begin
            errors++;
            $display("FAIL oneshot_model %0d: out=%0d tc=%b done=%b required out=%0d tc=%b done=%b",
                     i, bus.out, bus.tc, bus.done, m_out, m_tc, m_done);
         end
      end
      checks++;
      if (tc_count != 1 || bus.out !== 8'd4 || bus.done !== 1'b1) begin
         errors++;
         $display("FAIL oneshot_hold: tc_pulses=%0d out=%0d done=%b required 1 pulse out=4 done=1",
                  tc_count, bus.out, bus.done);
      end
      bus.mode = 1'b1;
      do_load(2);
      checks++;
      if (bus.out !== 8'd2 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_reload: out=%0d done=%b required out=2 done=0", bus.out, bus.done);
      end
      cycle();
      cycle();
      checks++;
      if (bus.out !== 8'd4 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL oneshot_resume: out=%0d done=%b required out=4 done=0", bus.out, bus.done);
      end
   endtask

   task automatic test_priority();
      set_inputs(1'b1, 1'b1, 1'b0, 0, 5);
      do_load(5);
      do_load(7);   // tick at terminal on the same edge
      checks++;
      if (bus.out !== 8'd7 || bus.tc !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL prio_load_tick: out=%0d tc=%b done=%b required out=7 tc=0 done=0",
                  bus.out, bus.tc, bus.done);
      end
      rst = 1'b1;
      do_load(9);
      rst = 1'b0;
      checks++;
      if (bus.out !== 8'd0 || bus.tc !== 1'b0) begin
         errors++;
         $display("FAIL prio_rst_load: out=%0d tc=%b required out=0 tc=0", bus.out, bus.tc);
      end
   endtask

   task automatic test_above_limit();
      set_inputs(1'b1, 1'b1, 1'b0, 0, 10);
      do_load(200);
      cycle();
      checks++;
      if (bus.out !== 8'd0 || bus.tc !== 1'b1) begin
         errors++;
         $display("FAIL above_limit: out=%0d tc=%b required out=0 tc=1", bus.out, bus.tc);
      end
      bus.max_val = '0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         checks++;
         if (bus.out !== 8'd0 || bus.tc !== 1'b1) begin
            errors++;
            $display("FAIL max_zero %0d: out=%0d tc=%b required out=0 tc=1", i, bus.out, bus.tc);
         end
      end
   endtask

   task automatic test_full_width();
      set_inputs(1'b1, 1'b1, 1'b0, 0, 255);
      do_load(254);
      cycle();
      checks++;
      if (bus.out !== 8'd255 || bus.tc !== 1'b0) begin
         errors++;
         $display("FAIL full_up_255: out=%0d tc=%b required out=255 tc=0", bus.out, bus.tc);
      end
      cycle();
      checks++;
      if (bus.out !== 8'd0 || bus.tc !== 1'b1) begin
         errors++;
         $display("FAIL full_up_wrap: out=%0d tc=%b required out=0 tc=1", bus.out, bus.tc);
      end
      bus.up_dn = 1'b0;
      cycle();
      checks++;
      if (bus.out !== 8'd255 || bus.tc !== 1'b1) begin
         errors++;
         $display("FAIL full_down_wrap: out=%0d tc=%b required out=255 tc=1", bus.out, bus.tc);
      end
      cycle();
      checks++;
      if (bus.out !== 8'd254 || bus.tc !== 1'b0) begin
         errors++;
         $display("FAIL full_down_step: out=%0d tc=%b required out=254 tc=0", bus.out, bus.tc);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst          = ($urandom_range(0, 99) < 2);
         bus.load     = ($urandom_range(0, 99) < 6);
         bus.load_val = WIDTH'($urandom_range(0, 20));
         bus.en       = ($urandom_range(0, 99) < 80);
         bus.up_dn    = 1'($urandom);
         bus.mode     = ($urandom_range(0, 99) < 20);
         bus.prescale = PRE_W'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) bus.max_val = WIDTH'($urandom_range(0, 15));
         cycle();
         checks++;
         if (bus.out !== m_out || bus.tc !== m_tc || bus.done !== m_done) begin
            errors++;
            $display("FAIL random %0d: out=%0d tc=%b done=%b required out=%0d tc=%b done=%b",
                     i, bus.out, bus.tc, bus.done, m_out, m_tc, m_done);
         end
      end
      rst = 1'b0;
      bus.load = 1'b0;
   endtask

   initial begin
      m_out = '0; m_pcnt = 0; m_tc = 1'b0; m_done = 1'b0; m_halted = 0;
      test_reset();
      test_wrap();
      test_prescale_down();
      test_oneshot();
      test_priority();
      test_above_limit();
      test_full_width();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mod_counter.md
Name: mod_counter

Overview:
- Parametrised successor to the basic 8-bit free-running up-counter.
- Adds up/down direction, a programmable modulo limit and an enable-gated prescaler.
- Adds parallel load, wrap or one-shot modes, and a terminal-count pulse.
- Used as the general timing/event counter for blinkers, timeouts and divided ticks in the FPGA lab designs.

Parameters:
- WIDTH, 8, counter width in bits.
- PRE_W, 8, prescaler divisor width in bits.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; gates the prescaler.
- up_dn  in  1  direction: 1 = up, 0 = down.
- mode  in  1  0 = wrap (free-run), 1 = one-shot (halt at terminal).
- prescale  in  PRE_W  tick every prescale+1 enabled cycles; 0 = every enabled cycle.
- max_val  in  WIDTH  modulo limit; count range 0..max_val.
- load  in  1  synchronous parallel load strobe.
- load_val  in  WIDTH  value written on load.
- out  out  WIDTH  registered count value.
- tc  out  1  registered one-cycle terminal-count pulse.
- done  out  1  registered, sticky; one-shot has halted.

Behaviour:
- Reset: on a clk edge with rst=1, out=0, tc=0, done=0, prescaler count=0, state=RUN.
- Priority per edge: rst > load > tick.
- Load: out<=load_val, done<=0, state<=RUN, prescaler cleared, tc<=0. load_val above max_val is accepted unchanged.
- Prescaler:
  - pcnt increments on each en=1 cycle.
  - When en=1 and pcnt>=prescale, tick=1 that cycle and pcnt<=0.
  - en=0 freezes pcnt.
  - Because the compare is >=, lowering prescale mid-count takes effect at once.
- Tick in RUN, up_dn=1:
  - If out>=max_val (terminal), out<=0 in wrap mode; in one-shot mode out holds.
  - Otherwise out<=out+1.
- Tick in RUN, up_dn=0:
  - If out==0 (terminal), out<=max_val in wrap mode; in one-shot mode out holds.
  - Otherwise out<=out-1.
- Terminal tick: tc<=1 in the following cycle only. In mode=1, state<=DONE and done<=1 in the same edge.
- tc is 0 in every cycle not immediately after a terminal tick.
- Back-to-back terminal ticks (max_val=0, prescale=0, wrap) hold tc=1 continuously.
- DONE state: out frozen, ticks ignored, tc=0. Exits only via load or rst.
- Changing mode from 1 to 0 while in DONE does not restart counting; load is required.
- max_val=0: the counter sits at 0 and every tick is terminal.
- Direction change is honoured on the next tick. Terminal detection uses the current up_dn.
- All arithmetic is modulo 2^WIDTH. No combinational input-to-output paths; all outputs are registered.
- Latency: a tick at edge n updates out at edge n. A load at edge n gives out=load_val after edge n.
- State machine: RUN, DONE.
  - RUN -> DONE on a terminal tick with mode=1.
  - DONE -> RUN on load.
  - Any state -> RUN on rst.

Decomposition:
- Shared package holds:
  - state typedef {RUN, DONE};
  - mode constants MODE_WRAP=0, MODE_ONESHOT=1;
  - direction constants DIR_DOWN=0, DIR_UP=1.
- One sub-module, tick_prescaler (PRE_W):
  - inputs: clk, rst, en, clr, prescale;
  - output: tick (combinational, from registered pcnt).
  - mod_counter drives clr from load.

Test Plan:
1. Reset and basic wrap: rst 1 cycle; en=1, up_dn=1, mode=0, prescale=0, max_val=5. Expect out sequence 0,1,2,3,4,5,0,1. tc=1 in the cycle out first reads 0 after 5; done=0.
2. Prescaled down-count: prescale=2, up_dn=0, max_val=3, load_val=3 loaded. Expect out to change every 3rd enabled cycle: 3,2,1,0,3. Deasserting en for 4 cycles mid-count freezes both out and the prescaler phase.
3. One-shot: mode=1, up_dn=1, max_val=4, from 0. Expect out reaches 4 and holds. Expect tc=1 for exactly one cycle and done=1 sticky. A further 10 ticks keep out=4 and tc=0. Then load load_val=2: done=0, counting resumes 3,4.
4. Priority: assert load (load_val=0x7) and a tick on the same edge while at terminal. Expect out=7, tc=0, done=0. Assert rst and load together: out=0.
5. Above-limit load: max_val=10, load_val=200, up. Expect next tick out=0 with tc pulse. With max_val=0, out stays 0 and tc=1 every tick cycle.
6. Full width: WIDTH=8, max_val=255, up, wrap. Expect out goes 255 -> 0 with tc pulse. Down from 0 goes to 255 with tc pulse.
